fetch_unit: RTL

Instruction fetch stage. It owns the PC and issues one-outstanding-request reads to instruction memory. It presents the fetched instruction, with opcode/funct pre-sliced, to the control unit and the IF/ID boundary. It consumes the control unit's jump and pc_src redirect outputs, discarding wrong-path fetches already in flight.

---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC owner, single outstanding imem read, IF/ID register
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_kill_cnt
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_inflight_q;
    logic [31:0] hold_instr_q;
    logic        req_valid_q;
    logic        kill_q;
    logic        if_valid_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc_plus4_q;

    logic        redirect_d;
    logic [31:0] redirect_pc_d;
    logic        req_fire_d;
    logic        resp_live_d;
    logic        resp_drop_d;
    logic        hold_drop_d;
    logic        load_d;
    logic [31:0] load_instr_d;

    assign redirect_d    = jump | pc_src;
    assign redirect_pc_d = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
    assign req_fire_d    = (state_q == S_REQ) & req_valid_q & imem_req_ready;
    // A response that meets a redirect in the same cycle is already wrong-path.
    assign resp_live_d   = (state_q == S_WAIT) & imem_resp_valid & ~kill_q & ~redirect_d;
    assign resp_drop_d   = (state_q == S_WAIT) & imem_resp_valid & (kill_q | redirect_d);
    assign hold_drop_d   = (state_q == S_HOLD) & redirect_d;
    assign load_d        = ~stall & (resp_live_d | ((state_q == S_HOLD) & ~redirect_d));
    assign load_instr_d  = (state_q == S_HOLD) ? hold_instr_q : imem_resp_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            pc_inflight_q <= 32'h0;
            hold_instr_q  <= 32'h0;
            req_valid_q   <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire_d) begin
                        state_q       <= S_WAIT;
                        req_valid_q   <= 1'b0;
                        pc_inflight_q <= pc_q;
                        kill_q        <= redirect_d;
                    end else begin
                        req_valid_q   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        kill_q <= 1'b0;
                        if (resp_live_d && stall) begin
                            state_q      <= S_HOLD;
                            hold_instr_q <= imem_resp_data;
                            req_valid_q  <= 1'b0;
                        end else begin
                            state_q      <= S_REQ;
                            req_valid_q  <= 1'b1;
                        end
                    end else if (redirect_d) begin
                        kill_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_d || !stall) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_REQ;
                    req_valid_q <= 1'b1;
                end
            endcase
            if (redirect_d) begin
                pc_q <= redirect_pc_d;
            end else if (req_fire_d) begin
                pc_q <= pc_q + PC_STEP;
            end
        end
    end

    // Flush beats stall; stall only freezes what is already in IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'h0;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= 32'h0;
        end else if (redirect_d) begin
            if_valid_q    <= 1'b0;
        end else if (load_d) begin
            if_valid_q    <= 1'b1;
            if_instr_q    <= load_instr_d;
            if_pc_q       <= pc_inflight_q;
            if_pc_plus4_q <= pc_inflight_q + PC_STEP;
        end else if (!stall) begin
            if_valid_q    <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_kill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= 32'h0;
            perf_kill_q  <= 32'h0;
        end else begin
            if (load_d) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (resp_drop_d || hold_drop_d) begin
                perf_kill_q <= perf_kill_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_kill_cnt  = perf_kill_q;
`endif

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    assign if_pc_plus4    = if_pc_plus4_q;
    assign opcode         = if_instr_q[31:26];
    assign funct          = if_instr_q[5:0];

endmodule
